// File: rtl/dac_source_scheduler.sv
// Timed source arbiter for the RFDC DAC AXIS port (DDS vs. direct-write) with zero-beat blanking on switch.
// Optional DAC_SCHED_SWITCH_CNT_EN adds a saturating switch_count output.
module dac_source_scheduler #(
  parameter int AXIS_DATA_WIDTH = 256,
  parameter int QUEUE_DEPTH     = 4,
  parameter int BLANK_CYCLES    = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [63:0]                 counter,
  input  logic                        auto_start,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_src,
  input  logic [63:0]                 req_time,
  input  logic [AXIS_DATA_WIDTH-1:0]  dds_tdata,
  input  logic                        dds_tvalid,
  input  logic [AXIS_DATA_WIDTH-1:0]  dir_tdata,
  input  logic                        dir_tvalid,
  output logic                        dir_tready,
  output logic [AXIS_DATA_WIDTH-1:0]  m00_axis_tdata,
  output logic                        m00_axis_tvalid,
  input  logic                        m00_axis_tready,
  output logic                        active_src,
  output logic                        late_error,
  output logic [$clog2(QUEUE_DEPTH):0] pend_count
`ifdef DAC_SCHED_SWITCH_CNT_EN
  ,
  output logic [15:0]                 switch_count
`endif
);

  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int BW = (BLANK_CYCLES < 1) ? 1 : $clog2(BLANK_CYCLES + 1);

  typedef enum logic {ST_RUN = 1'b0, ST_BLANK = 1'b1} state_t;

  state_t        state;
  logic          q_src  [QUEUE_DEPTH];
  logic [63:0]   q_time [QUEUE_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          full;
  logic [BW-1:0] blank_cnt;
  logic          target;
  logic          adv;
  logic          accept;
  logic          fire;
  logic          head_src;
  logic [63:0]   head_time;

  assign head_src   = q_src[rd_ptr];
  assign head_time  = q_time[rd_ptr];
  assign req_ready  = !full;
  assign accept     = req_valid && !full;
  assign fire       = auto_start && (count != '0) && (counter >= head_time) && (state == ST_RUN);
  assign adv        = m00_axis_tready || !m00_axis_tvalid;
  assign dir_tready = (state == ST_RUN) && active_src && adv;
  assign pend_count = count;

  always_comb begin
    count_next = count;
    if (accept && !fire)
      count_next = count + 1'b1;
    else if (!accept && fire)
      count_next = count - 1'b1;
  end

  // full resets high so req_ready only rises on the first clock after reset release
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      full       <= 1'b1;
      late_error <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (req_time < counter)
          late_error <= 1'b1;
      end
      if (fire)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == (AW+1)'(QUEUE_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      q_src[wr_ptr]  <= req_src;
      q_time[wr_ptr] <= req_time;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_RUN;
      active_src      <= 1'b0;
      target          <= 1'b0;
      blank_cnt       <= '0;
      m00_axis_tdata  <= '0;
      m00_axis_tvalid <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (adv) begin
            if (active_src) begin
              m00_axis_tdata  <= dir_tdata;
              m00_axis_tvalid <= dir_tvalid;
            end else begin
              m00_axis_tdata  <= dds_tdata;
              m00_axis_tvalid <= dds_tvalid;
            end
          end
          // a request naming the already-active source is simply consumed
          if (fire && (head_src != active_src)) begin
            if (BLANK_CYCLES == 0) begin
              active_src <= head_src;
            end else begin
              state     <= ST_BLANK;
              blank_cnt <= BW'(BLANK_CYCLES);
              target    <= head_src;
            end
          end
        end
        ST_BLANK: begin
          if (adv) begin
            m00_axis_tdata  <= '0;
            m00_axis_tvalid <= 1'b1;
            blank_cnt       <= blank_cnt - 1'b1;
            if (blank_cnt == BW'(1)) begin
              active_src <= target;
              state      <= ST_RUN;
            end
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef DAC_SCHED_SWITCH_CNT_EN
  logic switch_done;

  assign switch_done = ((BLANK_CYCLES == 0) && fire && (head_src != active_src)) ||
                       ((state == ST_BLANK) && adv && (blank_cnt == BW'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      switch_count <= '0;
    else if (switch_done && (switch_count != 16'hFFFF))
      switch_count <= switch_count + 16'd1;
  end
`endif

endmodule
